// File: rtl/camera_pixel_assembler.sv
// OV7670 byte-stream to RGB565 pixel assembler, pixel-clock domain only.
// Optional colour-bar generator: define CAMERA_TEST_PATTERN_EN.
module camera_pixel_assembler #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240
) (
   input  logic        pixel_clock_in,
   input  logic        reset_n_in,
   input  logic [7:0]  camera_data_in,
   input  logic        camera_href_in,
   input  logic        camera_vsync_in,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic        frame_done,
   output logic [8:0]  pixel_x,
   output logic [7:0]  pixel_y,
   output logic [7:0]  frame_count,
   output logic        frame_error
);

   localparam logic [8:0] W = 9'(FRAME_WIDTH);
   localparam logic [7:0] H = 8'(FRAME_HEIGHT);

   typedef enum logic [1:0] {
      WAIT_SYNC,
      LINE_IDLE,
      BYTE_LO,
      BYTE_HI
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  data_r_q;
   logic        href_r_q;
   logic        vsync_r_q;
   logic        vsync_p_q;
   logic [7:0]  hi_q, hi_d;
   logic [8:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [15:0] pixel_data_q, pixel_data_d;
   logic        pixel_valid_q, pixel_valid_d;
   logic        frame_done_q, frame_done_d;
   logic [8:0]  pixel_x_q, pixel_x_d;
   logic [7:0]  pixel_y_q, pixel_y_d;
   logic [7:0]  frame_count_q, frame_count_d;
   logic        frame_error_q, frame_error_d;
   logic        vs_rise, vs_fall;
   logic        in_bounds;
   logic [8:0]  x_inc;
   logic [7:0]  y_inc;
   logic [15:0] pix_word;

   assign vs_rise   = vsync_r_q & ~vsync_p_q;
   assign vs_fall   = ~vsync_r_q & vsync_p_q;
   assign in_bounds = (x_q < W) && (y_q < H);
   assign x_inc     = (x_q < W) ? x_q + 9'd1 : W;
   assign y_inc     = (y_q < H) ? y_q + 8'd1 : H;

`ifdef CAMERA_TEST_PATTERN_EN
   logic [2:0] bar;

   // Colour bar for the column being completed
   always_comb begin
      bar = 3'((32'(x_q) * 32'd8) / 32'(FRAME_WIDTH));
      case (bar)
         3'd0:    pix_word = 16'hFFFF;
         3'd1:    pix_word = 16'hFFE0;
         3'd2:    pix_word = 16'h07FF;
         3'd3:    pix_word = 16'h07E0;
         3'd4:    pix_word = 16'hF81F;
         3'd5:    pix_word = 16'hF800;
         3'd6:    pix_word = 16'h001F;
         default: pix_word = 16'h0000;
      endcase
   end
`else
   assign pix_word = {hi_q, data_r_q};
`endif

   // Input stage: one register on every camera pin, plus vsync history
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         data_r_q  <= 8'd0;
         href_r_q  <= 1'b0;
         vsync_r_q <= 1'b0;
         vsync_p_q <= 1'b0;
      end else begin
         data_r_q  <= camera_data_in;
         href_r_q  <= camera_href_in;
         vsync_r_q <= camera_vsync_in;
         vsync_p_q <= vsync_r_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q       <= WAIT_SYNC;
         hi_q          <= 8'd0;
         x_q           <= 9'd0;
         y_q           <= 8'd0;
         pixel_data_q  <= 16'd0;
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         pixel_x_q     <= 9'd0;
         pixel_y_q     <= 8'd0;
         frame_count_q <= 8'd0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hi_q          <= hi_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
         frame_done_q  <= frame_done_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         frame_count_q <= frame_count_d;
         frame_error_q <= frame_error_d;
      end
   end

   // Next state: vsync rise always ends the frame outside WAIT_SYNC
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_SYNC: if (vs_fall) state_d = LINE_IDLE;
         LINE_IDLE: begin
            if (vs_rise)       state_d = WAIT_SYNC;
            else if (href_r_q) state_d = BYTE_LO;
         end
         BYTE_LO: begin
            if (vs_rise)       state_d = WAIT_SYNC;
            else if (href_r_q) state_d = BYTE_HI;
            else               state_d = LINE_IDLE;
         end
         BYTE_HI: begin
            if (vs_rise)       state_d = WAIT_SYNC;
            else if (href_r_q) state_d = BYTE_LO;
            else               state_d = LINE_IDLE;
         end
         default:              state_d = WAIT_SYNC;
      endcase
   end

   // Outputs, counters and error tracking per state
   always_comb begin
      hi_d          = hi_q;
      x_d           = x_q;
      y_d           = y_q;
      pixel_data_d  = pixel_data_q;
      pixel_valid_d = 1'b0;
      frame_done_d  = 1'b0;
      pixel_x_d     = pixel_x_q;
      pixel_y_d     = pixel_y_q;
      frame_count_d = frame_count_q;
      frame_error_d = frame_error_q;
      if (state_q == WAIT_SYNC) begin
         if (vs_fall) begin
            x_d           = 9'd0;
            y_d           = 8'd0;
            frame_error_d = 1'b0;
         end
      end else if (vs_rise) begin
         frame_done_d  = 1'b1;
         frame_count_d = frame_count_q + 8'd1;
         if (href_r_q || state_q == BYTE_LO || y_q != H)
            frame_error_d = 1'b1;
      end else begin
         case (state_q)
            LINE_IDLE: if (href_r_q) hi_d = data_r_q;
            BYTE_LO: begin
               if (href_r_q) begin
                  if (in_bounds) begin
                     pixel_valid_d = 1'b1;
                     pixel_data_d  = pix_word;
                     pixel_x_d     = x_q;
                     pixel_y_d     = y_q;
                  end else begin
                     frame_error_d = 1'b1;
                  end
                  x_d = x_inc;
               end else begin
                  frame_error_d = 1'b1;
                  x_d           = 9'd0;
                  y_d           = y_inc;
               end
            end
            BYTE_HI: begin
               if (href_r_q) begin
                  hi_d = data_r_q;
               end else begin
                  if (x_q != W) frame_error_d = 1'b1;
                  x_d = 9'd0;
                  y_d = y_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_done  = frame_done_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign frame_count = frame_count_q;
   assign frame_error = frame_error_q;

endmodule
